fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of one `fifo` instance among `NUM_REQ` producers. Each producer presents data with a request. The arbiter picks one winner per cycle, captures its word into a one-entry output register, and drives the FIFO write port from that register, holding the word while the FIFO reports full. An optional lock lets one producer keep ownership for a bounded burst.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_WIDTH`, 8: word width; matches the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum consecutive beats one producer may win while locked, 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; `reset`=0 clears all state immediately.
- `req` input NUM_REQ: producer i has a word on its data slice.
- `lock` input NUM_REQ: producer i requests to keep ownership after its current beat.
- `req_data` input NUM_REQ*DATA_WIDTH: word of producer i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt` output NUM_REQ: one-hot accept strobe; word of producer i consumed this cycle.
- `fifo_full` input 1: FIFO `full`.
- `fifo_wr_en` output 1: to FIFO `wr_en`.
- `fifo_wdata` output DATA_WIDTH: to FIFO `wdata`.
- `owner` output clog2(NUM_REQ): index of the last granted producer, for debug and verification.

## Operation
- **Output register.** `out_valid`/`out_data` drive `fifo_wr_en = out_valid` and `fifo_wdata = out_data`.
  - The word is retired on an edge where `out_valid & ~fifo_full`.
- **Accept condition.** `can_accept = ~out_valid | ~fifo_full`.
  - Gives single-entry pass-through: one word per cycle at full rate when the FIFO is not full.
- **Arbitration (combinational, same cycle as `req`).** Only when `can_accept`.
  - State ARB: search `req` starting at `(owner+1) mod NUM_REQ`, wrapping. The first set bit wins.
  - State LOCKED: if `req[owner]`=1, `owner` wins. Otherwise fall back to the ARB search.
  - A grant asserts `gnt[w]`=1 for that cycle only. At the edge: `out_data <= req_data[w]`, `out_valid <= 1`, `owner <= w`.
  - No grant with `can_accept`: `out_valid <= 0` if the held word retired.
- **Burst counter `burst_cnt`.** 4 bits, saturating arithmetic not needed (bounded by MAX_BURST).
  - Grant in ARB with `lock[w]`=1 and MAX_BURST>1: go to LOCKED, `burst_cnt <= 1`.
  - Grant in LOCKED to `owner`: `burst_cnt <= burst_cnt+1`.
    - If the new count equals MAX_BURST or `lock[owner]`=0, go to ARB.
  - LOCKED with `req[owner]`=0: go to ARB, and the fallback grant (if any) is treated as an ARB grant.
  - While `~can_accept`: state and counter hold.
- **Producer contract.** `req[i]` and its data stay stable until `gnt[i]`. The arbiter never asserts `gnt[i]` without `req[i]`.
- **No drops.** A word is written exactly once. While `fifo_full`=1 the held word stays on `fifo_wdata` with `fifo_wr_en`=1; the FIFO gates it internally.
- **Illegal inputs.** `lock[i]` without `req[i]` is ignored.

## Timing
- **Reset values (`reset`=0, asynchronous):**
  - `out_valid`=0, so `fifo_wr_en`=0.
  - `fifo_wdata`=0.
  - `gnt`=0. Forced low asynchronously by gating with an internal reset flag.
  - `owner`=NUM_REQ-1, so producer 0 has top priority after reset.
  - State ARB, `burst_cnt`=0.
- **Reset mid-operation.** A held word is discarded and no partial burst survives. First grant possible on the first edge after `reset` returns to 1.
- **Latency.** `gnt[i]` in cycle T gives `fifo_wr_en`=1 with that word in cycle T+1, written at the end of T+1 if `fifo_full`=0.
- **Throughput.** One grant per cycle while the FIFO is not full.
- **Full.** `fifo_full`=1 with `out_valid`=1 gives no `gnt` that cycle.
  - First grant in the cycle `fifo_full` deasserts; the held word retires at that same edge.
- **Fairness.** Without lock, a continuously requesting producer waits at most NUM_REQ-1 grants. With lock, at most (NUM_REQ-1)*MAX_BURST.

## Test plan
- **Reset check.** Drive `reset`=0 with `req`=4'b1111 → `gnt`=0 and `fifo_wr_en`=0 throughout. Release reset → first `gnt`=4'b0001, next edge `fifo_wdata`=req_data[0].
- **Rotation.** `req`=4'b1111 held, `lock`=0, FIFO never full, data 8'hA0..8'hA3 → `gnt` sequence 0001,0010,0100,1000,0001. FIFO receives A0,A1,A2,A3,A0, one per cycle.
- **Backpressure.** Grant producer 2 (8'h5C), then hold `fifo_full`=1 for 3 cycles → `fifo_wr_en`=1 and `fifo_wdata`=8'h5C steady, `gnt`=0. Release → the next grant occurs in the release cycle, and 5C is written exactly once.
- **Locked burst.** MAX_BURST=4, `req`=4'b0011, `lock`=4'b0001 → `gnt[0]` on 4 consecutive cycles, then `gnt[1]`, then `gnt[0]`.
- **Early unlock.** Producer 0 drops `req` after 2 locked beats → `gnt[1]` the next cycle and the state returns to ARB.
- **End-to-end.** Fill an 8-deep `fifo` via 3 random producers until full, then drain → read order equals grant order, with no lost or duplicated word.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for fifo_wr_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment that drives producers and the FIFO full flag.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wdata;
    logic [OWNER_W-1:0]            owner;

    modport slave (
        input  req,
        input  lock,
        input  req_data,
        input  fifo_full,
        output gnt,
        output fifo_wr_en,
        output fifo_wdata,
        output owner
    );

    modport master (
        output req,
        output lock,
        output req_data,
        output fifo_full,
        input  gnt,
        input  fifo_wr_en,
        input  fifo_wdata,
        input  owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FIFO write port among NUM_REQ
// producers. A one-entry output register drives the FIFO and holds the word
// while the FIFO is full. An optional lock keeps ownership for up to MAX_BURST
// consecutive beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              burst_cnt_q, burst_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [OWNER_W-1:0]      owner_q, owner_d;

    logic                    in_reset;
    logic                    can_accept;
    logic                    lock_hit;
    logic                    arb_found;
    logic [OWNER_W-1:0]      arb_idx;
    logic [OWNER_W-1:0]      cand_idx;
    int unsigned             search_pos;
    logic                    grant;
    logic [OWNER_W-1:0]      win_idx;
    logic [NUM_REQ-1:0]      gnt_raw;

    // Grants are combinational, so they are gated by the reset level itself.
    assign in_reset = ~reset;

    // Round-robin search starting one past the last owner, wrapping around.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        cand_idx   = '0;
        search_pos = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            search_pos = (32'(owner_q) + off) % NUM_REQ;
            cand_idx   = OWNER_W'(search_pos);
            if (!arb_found && bus.req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Winner selection, burst tracking and next output-register contents.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        owner_d     = owner_q;
        gnt_raw     = '0;
        grant       = 1'b0;
        win_idx     = '0;

        can_accept = ~out_valid_q | ~bus.fifo_full;
        lock_hit   = (state_q == LOCKED) && bus.req[owner_q];

        if (can_accept) begin
            if (lock_hit) begin
                grant       = 1'b1;
                win_idx     = owner_q;
                burst_cnt_d = burst_cnt_q + 4'd1;
                if ((burst_cnt_d == 4'(MAX_BURST)) || !bus.lock[owner_q]) begin
                    state_d = ARB;
                end
            end else if (arb_found) begin
                // Also reached from LOCKED when the owner stopped requesting:
                // the fallback winner is handled exactly like an ARB grant.
                grant   = 1'b1;
                win_idx = arb_idx;
                if (bus.lock[arb_idx] && (MAX_BURST > 1)) begin
                    state_d     = LOCKED;
                    burst_cnt_d = 4'd1;
                end else begin
                    state_d     = ARB;
                    burst_cnt_d = '0;
                end
            end else begin
                state_d     = ARB;
                burst_cnt_d = '0;
            end

            // Held word (if any) retires now; register refills only on a grant.
            out_valid_d = grant;
            if (grant) begin
                out_data_d       = bus.req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                owner_d          = win_idx;
                gnt_raw[win_idx] = 1'b1;
            end
        end
    end

    // State, burst counter, owner and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            owner_q     <= OWNER_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            owner_q     <= owner_d;
        end
    end

    assign bus.gnt        = in_reset ? '0 : gnt_raw;
    assign bus.fifo_wr_en = out_valid_q;
    assign bus.fifo_wdata = out_data_q;
    assign bus.owner      = owner_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and end-to-end bench for fifo_wr_arbiter with a write scoreboard.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus_if ();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  data [N];
    logic [7:0]  exp_q [$];
    logic [7:0]  fifo_q [$];
    logic [7:0]  ord_q [$];
    bit          e2e_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f);
        bus_if.req       = r;
        bus_if.lock      = l;
        bus_if.fifo_full = f;
        for (int i = 0; i < N; i++) bus_if.req_data[i*DW +: DW] = data[i];
    endtask

    // Called at posedge+1: drive, settle, check gnt, record the expected word.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic f, input logic [3:0] eg);
        drive(r, l, f);
        #1;
        check(tag, 32'(bus_if.gnt), 32'(eg));
        for (int i = 0; i < N; i++) if (eg[i]) exp_q.push_back(data[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        step("flush_gnt", 4'b0000, 4'b0000, 1'b0, 4'b0000);
        check("flush_wr_en_last", 32'(bus_if.fifo_wr_en), 32'd1);
        tick();
        step("flush_gnt2", 4'b0000, 4'b0000, 1'b0, 4'b0000);
        check("flush_idle", 32'(bus_if.fifo_wr_en), 32'd0);
        tick();
    endtask

    // Every word the FIFO accepts must be the next one the bench granted.
    always @(negedge clk) begin
        if (reset && bus_if.fifo_wr_en && !bus_if.fifo_full) begin
            if (e2e_mode) fifo_q.push_back(bus_if.fifo_wdata);
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL write_unexpected: observed %0h expected none", bus_if.fifo_wdata);
            end
            if (exp_q.size() > 0) check("fifo_write", 32'(bus_if.fifo_wdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [3:0] seq [5];
    logic [3:0] pend;
    logic [3:0] r;
    logic [3:0] eg;
    logic [7:0] got;
    logic       f;
    logic       can;
    int         m_owner;
    bit         m_valid;
    int         w;
    int         idx;
    int         full_seen;

    initial begin
        data[0] = 8'hA0; data[1] = 8'hA1; data[2] = 8'hA2; data[3] = 8'hA3;
        drive(4'b1111, 4'b0000, 1'b0);

        // Reset held with all producers requesting.
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus_if.gnt), 32'd0);
        check("rst_wr_en", 32'(bus_if.fifo_wr_en), 32'd0);
        check("rst_wdata", 32'(bus_if.fifo_wdata), 32'd0);
        check("rst_owner", 32'(bus_if.owner), 32'd3);
        tick();
        check("rst_gnt_hold", 32'(bus_if.gnt), 32'd0);
        check("rst_wr_en_hold", 32'(bus_if.fifo_wr_en), 32'd0);

        // Release, then rotation across all four producers.
        reset = 1'b1;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step("rot_gnt", 4'b1111, 4'b0000, 1'b0, seq[k]);
            if (k > 0) check("rot_wr_en", 32'(bus_if.fifo_wr_en), 32'd1);
            tick();
        end
        check("rot_owner", 32'(bus_if.owner), 32'd0);
        flush();

        // Backpressure: producer 2 holds while full, producer 1 waits.
        data[2] = 8'h5C; data[1] = 8'h11;
        step("bp_grant2", 4'b0100, 4'b0000, 1'b0, 4'b0100);
        tick();
        for (int k = 0; k < 3; k++) begin
            step("bp_full_gnt", 4'b0010, 4'b0000, 1'b1, 4'b0000);
            check("bp_full_wr_en", 32'(bus_if.fifo_wr_en), 32'd1);
            check("bp_full_wdata", 32'(bus_if.fifo_wdata), 32'h5C);
            tick();
        end
        step("bp_release_gnt", 4'b0010, 4'b0000, 1'b0, 4'b0010);
        tick();
        check("bp_next_wdata", 32'(bus_if.fifo_wdata), 32'h11);
        flush();

        // Locked burst of MAX_BURST beats, then rotation, then relock.
        data[0] = 8'hC0; data[1] = 8'hC1;
        seq[0] = 4'b0001; seq[1] = 4'b0001; seq[2] = 4'b0001; seq[3] = 4'b0001; seq[4] = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            step("lock_burst_gnt", 4'b0011, 4'b0001, 1'b0, seq[k]);
            tick();
        end
        step("lock_relock_gnt", 4'b0011, 4'b0001, 1'b0, 4'b0001);
        tick();

        // Early unlock: second locked beat, then owner drops its request.
        step("unlock_beat2", 4'b0011, 4'b0001, 1'b0, 4'b0001);
        tick();
        step("unlock_fallback", 4'b0010, 4'b0001, 1'b0, 4'b0010);
        tick();
        step("unlock_back_to_arb", 4'b0011, 4'b0001, 1'b0, 4'b0001);
        tick();
        flush();

        // Reset mid-operation discards the held word and the partial burst.
        step("mid_lock_gnt", 4'b0010, 4'b0010, 1'b0, 4'b0010);
        tick();
        step("mid_full_gnt", 4'b0010, 4'b0010, 1'b1, 4'b0000);
        check("mid_full_wr_en", 32'(bus_if.fifo_wr_en), 32'd1);
        tick();
        reset = 1'b0;
        drive(4'b0011, 4'b0000, 1'b1);
        void'(exp_q.pop_back());
        #1;
        check("mid_rst_wr_en", 32'(bus_if.fifo_wr_en), 32'd0);
        check("mid_rst_gnt", 32'(bus_if.gnt), 32'd0);
        check("mid_rst_owner", 32'(bus_if.owner), 32'd3);
        check("mid_rst_wdata", 32'(bus_if.fifo_wdata), 32'd0);
        tick();
        reset = 1'b1;
        step("mid_first_gnt", 4'b0011, 4'b0000, 1'b0, 4'b0001);
        tick();
        flush();

        // End-to-end: three random producers into an 8-deep FIFO, then drain.
        e2e_mode  = 1'b1;
        m_owner   = 0;
        m_valid   = 1'b0;
        full_seen = 0;
        pend      = '0;
        for (int cyc = 0; cyc < 300 && full_seen < 3; cyc++) begin
            f = (fifo_q.size() >= 8);
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    data[i] = 8'($urandom);
                end
            end
            r = pend;
            drive(r, 4'b0000, f);
            #1;
            can = !m_valid || !f;
            w   = -1;
            if (can) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_owner + k) % N;
                    if (w < 0 && r[idx]) w = idx;
                end
            end
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            check("e2e_gnt", 32'(bus_if.gnt), 32'(eg));
            if (w >= 0) begin
                exp_q.push_back(data[w]);
                ord_q.push_back(data[w]);
                pend[w] = 1'b0;
                m_owner = w;
            end
            if (can) m_valid = (w >= 0);
            if (f) full_seen++;
            tick();
        end
        check("e2e_reached_full", 32'(full_seen), 32'd3);

        for (int cyc = 0; cyc < 100 && ord_q.size() > 0; cyc++) begin
            if (fifo_q.size() > 0) begin
                got = fifo_q.pop_front();
                check("e2e_read_order", 32'(got), 32'(ord_q.pop_front()));
            end
            drive(4'b0000, 4'b0000, fifo_q.size() >= 8);
            tick();
        end
        check("e2e_all_read", 32'(ord_q.size()), 32'd0);
        check("e2e_no_extra", 32'(fifo_q.size()), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("end_idle", 32'(bus_if.fifo_wr_en), 32'd0);
        e2e_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
